// File: rtl/cacheline_adaptor.sv
// Cache-line <-> memory-burst adaptor.
// Splits a LINE_WIDTH cache line into BEATS = LINE_WIDTH/BURST_WIDTH memory beats
// for writes, and assembles BEATS memory beats into a line for reads.
// Optional build macro CACHELINE_ADAPTOR_PROTOCHK_EN adds a sticky protocol
// error flag err_o (stray resp_i in IDLE/DONE, or read_i and write_i together).
module cacheline_adaptor #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // cache side
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    // memory side
    output logic                   read_o,
    output logic                   write_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
`ifdef CACHELINE_ADAPTOR_PROTOCHK_EN
    ,
    output logic                   err_o
`endif
);

    localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_wline;
    logic [LINE_WIDTH-1:0]   r_rline;
    logic [LINE_WIDTH-1:0]   w_rline_nxt;
    logic                    w_accept;
    logic                    w_beat;

    assign w_accept  = (r_state == IDLE) && (read_i || write_i);
    // resp_i only counts as a beat while a burst is in flight
    assign w_beat    = resp_i && ((r_state == READ) || (r_state == WRITE));
    assign line_o    = r_rline;
    assign address_o = r_addr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory/cache handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        read_o      = 1'b0;
        write_o     = 1'b0;
        resp_o      = 1'b0;
        unique case (r_state)
            IDLE: begin
                // read has priority when both requests are present
                if (read_i) begin
                    w_state_nxt = READ;
                end else if (write_i) begin
                    w_state_nxt = WRITE;
                end
            end
            READ: begin
                read_o = 1'b1;
                if (resp_i && (r_cnt == LAST_BEAT)) begin
                    w_state_nxt = DONE;
                end
            end
            WRITE: begin
                write_o = 1'b1;
                if (resp_i && (r_cnt == LAST_BEAT)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                resp_o      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read line with the current beat merged into slice r_cnt; write beat mux
    always_comb begin
        w_rline_nxt = r_rline;
        burst_o     = '0;
        for (int b = 0; b < int'(BEATS); b++) begin
            if (r_cnt == CNT_W'(b)) begin
                w_rline_nxt[b*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                burst_o = r_wline[b*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

    // Datapath: latch request, count beats, assemble read line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            r_rline <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_addr <= address_i;
            if (!read_i) begin
                r_wline <= line_i;
            end
        end else if (w_beat) begin
            // wraps to zero after the last beat
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == READ) begin
                r_rline <= w_rline_nxt;
            end
        end
    end

`ifdef CACHELINE_ADAPTOR_PROTOCHK_EN
    logic r_err;

    // Sticky protocol error: stray response outside a burst, or conflicting requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (((r_state == IDLE) && read_i && write_i) ||
                     (resp_i && ((r_state == IDLE) || (r_state == DONE)))) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-002 SHALL have parameter BURST_WIDTH, default 64, memory beat width in bits; LINE_WIDTH/BURST_WIDTH (BEATS, default 4) is an integer and a power of two.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports on the cache side:
- read_i, input, 1, line read request
- write_i, input, 1, line write request
- address_i, input, ADDR_WIDTH, line address
- line_i, input, LINE_WIDTH, write data
- line_o, output, LINE_WIDTH, read data
- resp_o, output, 1, transaction done
REQ-007 SHALL have ports on the memory side:
- read_o, output, 1, burst read
- write_o, output, 1, burst write
- address_o, output, ADDR_WIDTH, burst address
- burst_o, output, BURST_WIDTH, write beat
- burst_i, input, BURST_WIDTH, read beat
- resp_i, input, 1, beat accepted/valid

Function
REQ-008 SHALL use FSM states IDLE, READ, WRITE, DONE.
REQ-009 IDLE: read_i sampled high -> READ; else write_i high -> WRITE. Read wins when both are high. On acceptance, latch address_i, and latch line_i for writes.
REQ-010 read_o SHALL be high exactly while in READ, and write_o exactly while in WRITE; both low in IDLE and DONE.
REQ-011 address_o SHALL equal the latched address from the cycle after acceptance until DONE exits; address_o is held, not incremented per beat.
REQ-012 SHALL keep a beat counter of log2(BEATS) bits, cleared on acceptance and incremented only on cycles with resp_i high in READ/WRITE.
REQ-013 READ: on each resp_i-high cycle, burst_i SHALL be stored into line slice [cnt*BURST_WIDTH +: BURST_WIDTH], beat 0 in the LSBs. resp_i may have gaps; low cycles hold state.
REQ-014 WRITE: burst_o SHALL present latched line slice cnt combinationally; the slice advances the cycle after each resp_i-high cycle.
REQ-015 On the resp_i-high cycle with cnt == BEATS-1 -> DONE; the counter wraps to 0.
REQ-016 DONE SHALL last exactly one cycle with resp_o high, then go to IDLE; resp_o SHALL be low in all other states.
REQ-017 line_o SHALL hold the assembled read line from DONE until the next read's first beat. A write SHALL NOT alter line_o.
REQ-018 read_i/write_i SHALL be ignored outside IDLE. A request still high in the IDLE cycle after DONE is a new transaction.
REQ-019 In IDLE, resp_i SHALL be ignored, and burst_i SHALL NOT be captured.
REQ-020 Minimum read or write latency SHALL be BEATS+2 cycles, measured from the request-sample edge to resp_o high: 1 cycle to enter READ/WRITE, BEATS beats, then DONE.

Reset
REQ-021 rst_n low SHALL immediately force:
- state = IDLE, counter = 0
- read_o = write_o = resp_o = 0
- line_o, address_o and burst_o = 0
REQ-022 Reset mid-transaction SHALL abort it without asserting resp_o; after rst_n rises, the first rising edge with a request starts a fresh transaction.

Configuration
REQ-023 When macro CACHELINE_ADAPTOR_PROTOCHK_EN is defined, SHALL add output err_o (1 bit), which is sticky.
- err_o sets on resp_i high in IDLE or DONE.
- err_o sets on read_i and write_i both high in IDLE.
- err_o clears only on reset.
REQ-024 Without CACHELINE_ADAPTOR_PROTOCHK_EN, err_o and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-025 Read, back-to-back beats: read_i=1 with address_i=0x0000_1040; resp_i high 4 consecutive cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}, resp_o high 1 cycle at cycle 6, address_o = 0x0000_1040 throughout.
REQ-026 Write with gaps: write_i=1 with line_i = {0xDD..,0xCC..,0xBB..,0xAA..}; resp_i pattern 1,0,1,0,1,1 -> burst_o sequence 0xAA..,0xBB..,0xCC..,0xDD.., each held across gaps; write_o drops and resp_o pulses the cycle after the 4th beat.
REQ-027 Simultaneous: read_i=write_i=1 in IDLE -> read transaction only, write_o never high; with PROTOCHK_EN, err_o=1.
REQ-028 Reset mid-read: rst_n low after 2 beats -> read_o=0 and resp_o=0 immediately. A later read of 4 beats 0x55.. returns line_o all 0x55.., proving the counter restarted at 0.
REQ-029 Stray response: resp_i=1 in IDLE with burst_i=0xFF.. -> line_o unchanged and no state change; with PROTOCHK_EN, err_o=1 and stays 1 until reset.
REQ-030 Back-to-back: read_i held high through DONE -> second read's read_o rises the cycle after the IDLE cycle; the two resp_o pulses are separated by ≥BEATS+1 cycles.
